// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared constants for the multicycle MIPS sequencer: opcodes,
//               funct codes, ALU control / aluop codes, mux select codes,
//               FSM state encodings and error codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011100;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;

  // aluop: what the FSM asks of the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alu_src_b selects
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_SIMM  = 2'b10;
  localparam logic [1:0] SRCB_SIMM4 = 2'b11;

  // pc_src selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM states
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [3:0] S_ERR     = 4'd12;

  // Error codes
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mips_alu_decoder
// Description : Maps (aluop, funct) to the 3-bit ALU control code.
//               Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  // aluop picks add/sub directly; funct is only consulted for R-type execute
  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_SLT:  alu_control = ALU_SLT;
          FN_MUL:  alu_control = ALU_MUL;
          default: alu_control = ALU_ADD;
        endcase
      end
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multicycle MIPS control FSM with memory ready handshake,
//               wait-state timeout and sticky error trap.
//               Optional macro MC_CTRL_PERF_EN adds perf_retired/perf_stall
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        iord,
  output logic        ir_wr,
  output logic        pc_en,
  output logic        reg_wr,
  output logic        reg_dst,
  output logic        mem2reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_control,
  output logic        instr_done,
  output logic [1:0]  err
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_stall
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [3:0]    state, next_state;
  logic [CW-1:0] wait_cnt, next_cnt;
  logic [1:0]    next_err;
  logic [1:0]    aluop;
  logic          mem_state, timeout;
  logic          mem_rd_c, mem_wr_c, ir_wr_c, pc_en_c, reg_wr_c, done_c;

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout   = mem_state && !mem_ready && (wait_cnt == CNT_LAST);

  // State, wait counter and sticky error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      err      <= ERR_NONE;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      err      <= next_err;
    end
  end

  // Next-state, timeout trap and wait-counter update
  always_comb begin
    next_state = state;
    next_err   = err;
    case (state)
      S_FETCH:   if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTYPEEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JEX;
          default: begin
            next_state = S_ERR;
            next_err   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:  next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR:   if (mem_ready) next_state = S_FETCH;
      S_RTYPEEX: next_state = S_RTYPEWB;
      S_RTYPEWB: next_state = S_FETCH;
      S_BEQEX:   next_state = S_FETCH;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_ADDIWB:  next_state = S_FETCH;
      S_JEX:     next_state = S_FETCH;
      S_ERR:     next_state = S_ERR;
      default:   next_state = S_ERR;
    endcase
    // A ready memory wins over the timeout in the same cycle
    if (timeout) begin
      next_state = S_ERR;
      next_err   = ERR_TIMEOUT;
    end
    next_cnt = wait_cnt;
    if ((next_state != state) &&
        ((next_state == S_FETCH) || (next_state == S_MEMRD) || (next_state == S_MEMWR)))
      next_cnt = '0;
    else if (mem_state && !mem_ready)
      next_cnt = wait_cnt + CW'(1);
  end

  // Per-state datapath controls; anything not set for a state stays 0
  always_comb begin
    mem_rd_c  = 1'b0;
    mem_wr_c  = 1'b0;
    iord      = 1'b0;
    ir_wr_c   = 1'b0;
    pc_en_c   = 1'b0;
    reg_wr_c  = 1'b0;
    reg_dst   = 1'b0;
    mem2reg   = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_B;
    pc_src    = PCSRC_ALU;
    aluop     = ALUOP_ADD;
    done_c    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd_c  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_wr_c   = mem_ready;
        pc_en_c   = mem_ready;
      end
      S_DECODE:  alu_src_b = SRCB_SIMM4;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SIMM;
      end
      S_MEMRD: begin
        mem_rd_c = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_wr_c = 1'b1;
        mem2reg  = 1'b1;
        done_c   = 1'b1;
      end
      S_MEMWR: begin
        mem_wr_c = 1'b1;
        iord     = 1'b1;
        done_c   = mem_ready;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        reg_wr_c = 1'b1;
        reg_dst  = 1'b1;
        done_c   = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en_c   = zero;
        done_c    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SIMM;
      end
      S_ADDIWB: begin
        reg_wr_c = 1'b1;
        done_c   = 1'b1;
      end
      S_JEX: begin
        pc_src  = PCSRC_JUMP;
        pc_en_c = 1'b1;
        done_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are forced low for the whole time reset is asserted
  assign mem_rd     = mem_rd_c & rst_n;
  assign mem_wr     = mem_wr_c & rst_n;
  assign ir_wr      = ir_wr_c  & rst_n;
  assign pc_en      = pc_en_c  & rst_n;
  assign reg_wr     = reg_wr_c & rst_n;
  assign instr_done = done_c   & rst_n;

  mips_alu_decoder u_alu_dec (
    .aluop       (aluop),
    .funct       (funct),
    .alu_control (alu_control)
  );

`ifdef MC_CTRL_PERF_EN
  // Retired-instruction and memory-stall counters, frozen once trapped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else if (state != S_ERR) begin
      if (done_c)
        perf_retired <= perf_retired + 32'd1;
      if (mem_state && !mem_ready)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Directed self-checking bench for mips_multicycle_ctrl
//               (TIMEOUT=4, default build without MC_CTRL_PERF_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  localparam logic [2:0] AC_ADD = 3'b010;
  localparam logic [2:0] AC_SUB = 3'b100;
  localparam logic [2:0] AC_SLT = 3'b110;
  localparam logic [2:0] AC_MUL = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_rd, mem_wr, iord, ir_wr, pc_en, reg_wr, reg_dst, mem2reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src, err;
  logic [2:0] alu_control;
  logic       instr_done;

  int passed = 0;
  int total  = 0;
  int wb_cnt, done_cnt;

  // Observed bundle: {rd,wr,iord,ir_wr,pc_en,reg_wr,reg_dst,mem2reg,src_a,src_b,pc_src,aluc,done,err}
  logic [18:0] obs;
  assign obs = {mem_rd, mem_wr, iord, ir_wr, pc_en, reg_wr, reg_dst, mem2reg, alu_src_a,
                alu_src_b, pc_src, alu_control, instr_done, err};

  mips_multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord), .ir_wr(ir_wr), .pc_en(pc_en),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .mem2reg(mem2reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control),
    .instr_done(instr_done), .err(err)
  );

  always #5 clk = ~clk;

  // Expected output bundles per state, written from the state table
  function automatic logic [18:0] e_rst();
    return {8'b0, 1'b0, 2'b01, 2'b00, AC_ADD, 1'b0, 2'b00};
  endfunction
  function automatic logic [18:0] e_fetch(input logic r, input logic [1:0] e);
    return {1'b1, 1'b0, 1'b0, r, r, 3'b000, 1'b0, 2'b01, 2'b00, AC_ADD, 1'b0, e};
  endfunction
  function automatic logic [18:0] e_decode(input logic [1:0] e);
    return {8'b0, 1'b0, 2'b11, 2'b00, AC_ADD, 1'b0, e};
  endfunction
  function automatic logic [18:0] e_memadr(input logic [1:0] e);
    return {8'b0, 1'b1, 2'b10, 2'b00, AC_ADD, 1'b0, e};
  endfunction
  function automatic logic [18:0] e_memrd(input logic [1:0] e);
    return {8'b1010_0000, 1'b0, 2'b00, 2'b00, AC_ADD, 1'b0, e};
  endfunction
  function automatic logic [18:0] e_memwb(input logic [1:0] e);
    return {8'b0000_0101, 1'b0, 2'b00, 2'b00, AC_ADD, 1'b1, e};
  endfunction
  function automatic logic [18:0] e_memwr(input logic r, input logic [1:0] e);
    return {8'b0110_0000, 1'b0, 2'b00, 2'b00, AC_ADD, r, e};
  endfunction
  function automatic logic [18:0] e_rtex(input logic [2:0] ac, input logic [1:0] e);
    return {8'b0, 1'b1, 2'b00, 2'b00, ac, 1'b0, e};
  endfunction
  function automatic logic [18:0] e_rtwb(input logic [1:0] e);
    return {8'b0000_0110, 1'b0, 2'b00, 2'b00, AC_ADD, 1'b1, e};
  endfunction
  function automatic logic [18:0] e_beq(input logic z, input logic [1:0] e);
    return {4'b0000, z, 3'b000, 1'b1, 2'b00, 2'b01, AC_SUB, 1'b1, e};
  endfunction
  function automatic logic [18:0] e_addiex(input logic [1:0] e);
    return {8'b0, 1'b1, 2'b10, 2'b00, AC_ADD, 1'b0, e};
  endfunction
  function automatic logic [18:0] e_addiwb(input logic [1:0] e);
    return {8'b0000_0100, 1'b0, 2'b00, 2'b00, AC_ADD, 1'b1, e};
  endfunction
  function automatic logic [18:0] e_jex(input logic [1:0] e);
    return {8'b0000_1000, 1'b0, 2'b00, 2'b10, AC_ADD, 1'b1, e};
  endfunction
  function automatic logic [18:0] e_err(input logic [1:0] e);
    return {8'b0, 1'b0, 2'b00, 2'b00, AC_ADD, 1'b0, e};
  endfunction

  task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %05h expected %05h", tag, o, e);
  endtask

  // One clock: apply mem_ready, check mid-cycle, then advance past the edge
  task automatic cyc(input string tag, input logic r, input logic [18:0] e);
    mem_ready = r;
    #1;
    chk(tag, obs, e);
    if (reg_wr && mem2reg) wb_cnt++;
    if (instr_done) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk(tag, obs, e_rst());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = 6'b0; funct = 6'b0;
    #2;
    chk("reset_idle", obs, e_rst());
    mem_ready = 1'b1;
    #1;
    chk("reset_ready", obs, e_rst());
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // lw with two wait states in FETCH and MEMRD: 9 cycles
    op = 6'b100011; wb_cnt = 0; done_cnt = 0;
    cyc("lw_f0", 1'b0, e_fetch(1'b0, 2'b00));
    cyc("lw_f1", 1'b0, e_fetch(1'b0, 2'b00));
    cyc("lw_f2", 1'b1, e_fetch(1'b1, 2'b00));
    cyc("lw_dec", 1'b0, e_decode(2'b00));
    cyc("lw_adr", 1'b0, e_memadr(2'b00));
    cyc("lw_rd0", 1'b0, e_memrd(2'b00));
    cyc("lw_rd1", 1'b0, e_memrd(2'b00));
    cyc("lw_rd2", 1'b1, e_memrd(2'b00));
    cyc("lw_wb", 1'b0, e_memwb(2'b00));
    chk("lw_wb_once", 19'(wb_cnt), 19'd1);
    chk("lw_done_once", 19'(done_cnt), 19'd1);

    // beq taken then not taken
    op = 6'b000100; zero = 1'b1;
    cyc("beq1_f", 1'b1, e_fetch(1'b1, 2'b00));
    cyc("beq1_dec", 1'b0, e_decode(2'b00));
    cyc("beq1_ex", 1'b0, e_beq(1'b1, 2'b00));
    zero = 1'b0;
    cyc("beq0_f", 1'b1, e_fetch(1'b1, 2'b00));
    cyc("beq0_dec", 1'b0, e_decode(2'b00));
    cyc("beq0_ex", 1'b0, e_beq(1'b0, 2'b00));

    // R-type slt, then unknown funct (and), then sub and mul
    op = 6'b000000; funct = 6'b101010;
    cyc("slt_f", 1'b1, e_fetch(1'b1, 2'b00));
    cyc("slt_dec", 1'b0, e_decode(2'b00));
    cyc("slt_ex", 1'b0, e_rtex(AC_SLT, 2'b00));
    cyc("slt_wb", 1'b0, e_rtwb(2'b00));
    funct = 6'b100100;
    cyc("and_f", 1'b1, e_fetch(1'b1, 2'b00));
    cyc("and_dec", 1'b0, e_decode(2'b00));
    cyc("and_ex", 1'b0, e_rtex(AC_ADD, 2'b00));
    cyc("and_wb", 1'b0, e_rtwb(2'b00));
    funct = 6'b100010;
    cyc("sub_f", 1'b1, e_fetch(1'b1, 2'b00));
    cyc("sub_dec", 1'b0, e_decode(2'b00));
    cyc("sub_ex", 1'b0, e_rtex(AC_SUB, 2'b00));
    cyc("sub_wb", 1'b0, e_rtwb(2'b00));
    funct = 6'b011100;
    cyc("mul_f", 1'b1, e_fetch(1'b1, 2'b00));
    cyc("mul_dec", 1'b0, e_decode(2'b00));
    cyc("mul_ex", 1'b0, e_rtex(AC_MUL, 2'b00));
    cyc("mul_wb", 1'b0, e_rtwb(2'b00));

    // addi and j
    op = 6'b001000;
    cyc("addi_f", 1'b1, e_fetch(1'b1, 2'b00));
    cyc("addi_dec", 1'b0, e_decode(2'b00));
    cyc("addi_ex", 1'b0, e_addiex(2'b00));
    cyc("addi_wb", 1'b0, e_addiwb(2'b00));
    op = 6'b000010;
    cyc("j_f", 1'b1, e_fetch(1'b1, 2'b00));
    cyc("j_dec", 1'b0, e_decode(2'b00));
    cyc("j_ex", 1'b0, e_jex(2'b00));

    // sw, memory ready on the 4th (last allowed) wait cycle
    op = 6'b101011;
    cyc("sw_f", 1'b1, e_fetch(1'b1, 2'b00));
    cyc("sw_dec", 1'b0, e_decode(2'b00));
    cyc("sw_adr", 1'b0, e_memadr(2'b00));
    cyc("sw_w0", 1'b0, e_memwr(1'b0, 2'b00));
    cyc("sw_w1", 1'b0, e_memwr(1'b0, 2'b00));
    cyc("sw_w2", 1'b0, e_memwr(1'b0, 2'b00));
    cyc("sw_w3_ready", 1'b1, e_memwr(1'b1, 2'b00));

    // sw with memory stuck: timeout trap after 4 cycles
    cyc("swt_f", 1'b1, e_fetch(1'b1, 2'b00));
    cyc("swt_dec", 1'b0, e_decode(2'b00));
    cyc("swt_adr", 1'b0, e_memadr(2'b00));
    cyc("swt_w0", 1'b0, e_memwr(1'b0, 2'b00));
    cyc("swt_w1", 1'b0, e_memwr(1'b0, 2'b00));
    cyc("swt_w2", 1'b0, e_memwr(1'b0, 2'b00));
    cyc("swt_w3", 1'b0, e_memwr(1'b0, 2'b00));
    cyc("swt_err0", 1'b1, e_err(2'b10));
    cyc("swt_err1", 1'b0, e_err(2'b10));
    cyc("swt_err2", 1'b1, e_err(2'b10));
    do_reset("swt_reset");
    cyc("swt_after", 1'b0, e_fetch(1'b0, 2'b00));

    // Illegal opcode: trap, then 20 cycles of silence
    op = 6'b111111;
    cyc("ill_f", 1'b1, e_fetch(1'b1, 2'b00));
    cyc("ill_dec", 1'b0, e_decode(2'b00));
    for (int i = 0; i < 20; i++)
      cyc("ill_err", 1'($urandom_range(0, 1)), e_err(2'b01));
    do_reset("ill_reset");

    // Reset asserted mid-MEMRD for one cycle
    op = 6'b100011;
    cyc("rm_f", 1'b1, e_fetch(1'b1, 2'b00));
    cyc("rm_dec", 1'b0, e_decode(2'b00));
    cyc("rm_adr", 1'b0, e_memadr(2'b00));
    mem_ready = 1'b0;
    #1;
    chk("rm_memrd", obs, e_memrd(2'b00));
    do_reset("rm_reset");
    cyc("rm_fetch", 1'b0, e_fetch(1'b0, 2'b00));
    cyc("rm_fetch_rdy", 1'b1, e_fetch(1'b1, 2'b00));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
